i2c_txn_arbiter: RTL and testbench

- Shares the single I2C byte transmitter between two requesters (0 = PLL/clock config, 1 = front-end/PGA config).
- Each requester asks for one write transaction: a 7-bit device address plus 0..15 payload bytes.
- Arbitration between requesters is round-robin.
- The block drives the transmitter's data/data_ready/en/data_req handshake, streams the payload from the granted requester, and reports completion on the transmitter's done pulse.

---
 rtl/i2c_txn_arbiter.sv | 107 ++++++++++
 tb/tb_i2c_txn_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte transmitter between two write requesters
module i2c_txn_arbiter #(
  parameter int HOLDOFF = 1024,
  parameter int HOLD_W  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       byte_ack0,
  output logic       byte_ack1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  output logic       tx_en,
  input  logic       tx_data_req,
  input  logic       tx_done
);
  typedef enum logic [1:0] {HOLD, IDLE, SEND, WAIT_DONE} state_t;
  state_t state;
  logic [HOLD_W-1:0] hold_cnt;
  logic last_grant, sel_addr, pick;
  logic [6:0] addr_q;
  logic [3:0] len_q, remaining;
  assign pick = (req0 & req1) ? ~last_grant : req1;
  assign tx_data = sel_addr ? {addr_q, 1'b0} : (gnt1 ? data1 : data0);
  assign busy = (state == SEND) || (state == WAIT_DONE);
  // arbitration, byte sequencing and completion; the holdoff lets an unreset transmitter drain
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      hold_cnt <= '0;
      last_grant <= 1'b1;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      byte_ack0 <= 1'b0;
      byte_ack1 <= 1'b0;
      tx_en <= 1'b0;
      tx_data_ready <= 1'b0;
      sel_addr <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      remaining <= '0;
    end else begin
      byte_ack0 <= 1'b0;
      byte_ack1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(HOLDOFF - 1)) state <= IDLE;
        end
        IDLE: if (req0 | req1) begin
          addr_q <= pick ? addr1 : addr0;
          len_q <= pick ? len1 : len0;
          remaining <= pick ? len1 : len0;
          gnt0 <= ~pick;
          gnt1 <= pick;
          tx_en <= 1'b1;
          tx_data_ready <= 1'b1;
          sel_addr <= 1'b1;
          state <= SEND;
        end
        SEND: if (tx_data_req) begin
          if (sel_addr) begin
            sel_addr <= 1'b0;
            if (len_q == 4'd0) begin
              tx_data_ready <= 1'b0;
              state <= WAIT_DONE;
            end
          end else begin
            byte_ack0 <= gnt0;
            byte_ack1 <= gnt1;
            remaining <= remaining - 1'b1;
            if (remaining == 4'd1) begin
              tx_data_ready <= 1'b0;
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: if (tx_done) begin
          done0 <= gnt0;
          done1 <= gnt1;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          tx_en <= 1'b0;
          last_grant <= gnt1;
          state <= IDLE;
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed vectors and transmitter-side sequences for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0;
  logic [6:0] addr0 = 0, addr1 = 0;
  logic [3:0] len0 = 0, len1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic byte_ack0, byte_ack1, gnt0, gnt1, done0, done1, busy, tx_data_ready, tx_en;
  logic [7:0] tx_data;
  logic tx_data_req = 0, tx_done = 0;
  int checks = 0, errors = 0;

  i2c_txn_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .data0(data0), .data1(data1),
    .byte_ack0(byte_ack0), .byte_ack1(byte_ack1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .busy(busy), .tx_data(tx_data),
    .tx_data_ready(tx_data_ready), .tx_en(tx_en), .tx_data_req(tx_data_req), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req0;
    logic       treq;
    logic       tdone;
    logic [7:0] d0;
    logic [7:0] exp_txd;
    logic [8:0] exp_out;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [8:0] outs();
    return {gnt0, gnt1, byte_ack0, byte_ack1, done0, done1, busy, tx_en, tx_data_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit s, input logic [6:0] a, input logic [3:0] n, input logic [7:0] d);
    int w = 0;
    int acks = 0;
    logic [1:0] g = s ? 2'b10 : 2'b01;
    while (!(gnt0 | gnt1) && w < 50) begin
      tick();
      w++;
    end
    chk("grant_side", 32'({gnt1, gnt0}), 32'(g));
    for (int b = 0; b <= int'(n); b++) begin
      chk("ready_pending", 32'(tx_data_ready), 1);
      tx_data_req = 1;
      #1 chk("tx_data", 32'(tx_data), b == 0 ? 32'({a, 1'b0}) : 32'(d));
      tick();
      tx_data_req = 0;
      acks += int'(s ? byte_ack1 : byte_ack0);
      chk("ack_other", 32'(s ? byte_ack0 : byte_ack1), 0);
      chk("gnt_held", 32'({gnt1, gnt0}), 32'(g));
      if (b < int'(n)) begin
        tick();
        acks += int'(s ? byte_ack1 : byte_ack0);
      end
    end
    chk("ready_low", 32'(tx_data_ready), 0);
    repeat (3) begin
      tick();
      acks += int'(s ? byte_ack1 : byte_ack0);
      chk("wait_gnt_held", 32'({gnt1, gnt0}), 32'(g));
    end
    chk("ack_count", 32'(acks), 32'(n));
    tx_done = 1;
    tick();
    tx_done = 0;
    chk("done_side", 32'({done1, done0}), 32'(g));
    chk("gnt_clear", 32'({gnt1, gnt0}), 0);
    chk("busy_clear", 32'(busy), 0);
    chk("en_clear", 32'(tx_en), 0);
  endtask

  initial begin
    int k;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'hA1, 9'b100000111};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hA1, 8'h90, 9'b100000111};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'hA1, 9'b100000111};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'hA1, 8'hA1, 9'b101000111};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'hB2, 8'hB2, 9'b100000111};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'hB2, 8'hB2, 9'b101000110};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'hB2, 8'hB2, 9'b100000110};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'hB2, 8'hB2, 9'b000010000};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'hB2, 8'hB2, 9'b000000000};

    rst = 1;
    repeat (2) tick();
    rst = 0;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_txd", 32'(tx_data), 0);
    repeat (1030) tick();
    chk("idle_outs", 32'(outs()), 0);

    addr0 = 7'h48;
    len0 = 4'd2;
    for (int i = 0; i < 9; i++) begin
      req0 = tbl[i].req0;
      tx_data_req = tbl[i].treq;
      tx_done = tbl[i].tdone;
      data0 = tbl[i].d0;
      #4 chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(tbl[i].exp_txd));
      tick();
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp_out));
    end
    tx_data_req = 0;
    tx_done = 0;

    addr1 = 7'h7F;
    len1 = 4'd0;
    data1 = 8'hC3;
    req1 = 1;
    xfer(1, 7'h7F, 4'd0, 8'hC3);
    req1 = 0;

    addr0 = 7'h10;
    len0 = 4'd1;
    data0 = 8'h11;
    addr1 = 7'h20;
    len1 = 4'd1;
    data1 = 8'h22;
    req0 = 1;
    req1 = 1;
    xfer(0, 7'h10, 4'd1, 8'h11);
    xfer(1, 7'h20, 4'd1, 8'h22);
    xfer(0, 7'h10, 4'd1, 8'h11);
    xfer(1, 7'h20, 4'd1, 8'h22);
    req0 = 0;
    req1 = 0;
    repeat (2) tick();

    len0 = 4'd2;
    data0 = 8'h44;
    req0 = 1;
    tick();
    chk("pre_gnt0", 32'({gnt1, gnt0}), 1);
    req1 = 1;
    xfer(0, 7'h10, 4'd2, 8'h44);
    req0 = 0;
    tick();
    chk("gnt1_after_done0", 32'({gnt1, gnt0}), 2);
    xfer(1, 7'h20, 4'd1, 8'h22);
    req1 = 0;
    repeat (2) tick();

    addr0 = 7'h11;
    len0 = 4'd3;
    data0 = 8'h33;
    req0 = 1;
    tick();
    chk("rst_txn_gnt", 32'(gnt0), 1);
    repeat (2) begin
      tx_data_req = 1;
      tick();
      tx_data_req = 0;
      tick();
    end
    tx_data_req = 1;
    rst = 1;
    tick();
    rst = 0;
    tx_data_req = 0;
    chk("rst_outs", 32'(outs()), 0);
    k = 0;
    while (!gnt0 && k < 1100) begin
      tx_done = (k == 10);
      tick();
      k++;
      if (k == 11) chk("done_in_hold", 32'({done1, done0}), 0);
    end
    tx_done = 0;
    chk("holdoff_cycles", 32'(k), 1025);
    xfer(0, 7'h11, 4'd3, 8'h33);
    req0 = 0;
    repeat (2) tick();

    addr0 = 7'h55;
    len0 = 4'd15;
    data0 = 8'h5A;
    req0 = 1;
    xfer(0, 7'h55, 4'd15, 8'h5A);
    req0 = 0;
    tick();
    chk("final_idle", 32'(outs()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
